binary16_divider: RTL and testbench
===================================

BINARY16_DIVIDER -- requirements
Module: binary16_divider

Interface
REQ-001 SHALL have parameter SAT_TO_INF, default 1, meaning overflow yields infinity when 1 and max finite (0x7BFF with sign) when 0.
REQ-002 SHALL have parameter QBITS, default 12, meaning the number of quotient bits developed, one per cycle.
REQ-003 SHALL have port clk_in, input, 1, the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, the reset: asynchronous and active-low.
REQ-005 SHALL have port a, input, 16, the binary16 dividend.
REQ-006 SHALL have port b, input, 16, the binary16 divisor.
REQ-007 SHALL have port data_valid_in, input, 1, operand strobe.
REQ-008 SHALL have port result, output, 16, the binary16 quotient a/b.
REQ-009 SHALL have port data_valid_out, output, 1, a one-cycle result strobe.
REQ-010 SHALL have port div_by_zero, output, 1, flag qualified by data_valid_out.
REQ-011 SHALL have port busy, output, 1, high while an operation is in flight.

Function
REQ-012 SHALL be a four-state FSM: IDLE, DIVIDE, NORM, DONE.
REQ-013 SHALL assert busy whenever the state is not IDLE.
REQ-014 SHALL, in IDLE on an edge with data_valid_in=1, register sign=a[15]^b[15], mant_a={1,a[9:0]}, mant_b={1,b[9:0]}, and the zero flags (x[14:0]==0), then enter DIVIDE.
REQ-015 SHALL ignore data_valid_in in every state other than IDLE, with no queueing and no corruption of the in-flight operation.
REQ-016 SHALL compute a signed 7-bit exponent, exp_q = exp_a - exp_b + 15, at accept.
REQ-017 SHALL run restoring division in DIVIDE, producing one quotient bit per cycle for QBITS cycles (counter 0..QBITS-1), then enter NORM.
REQ-018 SHALL, in NORM, use q[10:0] and exp_q-1 when quotient bit q[11]=0; otherwise it SHALL use q[11:1] and exp_q.
REQ-019 SHALL round by truncation: remainder and shifted-out bits are discarded.
REQ-020 SHALL, in NORM, resolve special cases in priority order: b zero, then a zero, then exponent out of range.
REQ-021 SHALL, when b is zero, produce {sign,5'h1F,10'h0} and set div_by_zero=1.
REQ-022 SHALL, when a is zero and b is nonzero, produce {sign,15'h0}.
REQ-023 SHALL flush the result to {sign,15'h0} when the adjusted exponent is below 1 (underflow).
REQ-024 SHALL, when the adjusted exponent is above 30 (overflow), produce infinity or max finite as set by SAT_TO_INF.
REQ-025 SHALL register the final result at the NORM->DONE edge.
REQ-026 SHALL, in DONE, hold data_valid_out=1 for exactly one cycle, then return to IDLE.
REQ-027 SHALL have a fixed latency for all operand classes, specials included: if accept occurs at edge N, data_valid_out is high in the cycle after edge N+QBITS+1 (13 with defaults).
REQ-028 SHALL accept the next operation no earlier than the edge after DONE, giving a throughput of one operation per QBITS+3 cycles.
REQ-029 SHALL drive result=16'h0 and div_by_zero=0 whenever data_valid_out=0.
REQ-030 SHALL treat nonzero inputs as normalized: exponent 0 means zero only, and Inf/NaN inputs are undefined.

Reset
REQ-031 SHALL, on rst_n low at any time, immediately force state=IDLE, busy=0, data_valid_out=0, result=0, div_by_zero=0 and counter=0.
REQ-032 SHALL discard an operation in flight at reset, producing no data_valid_out for it.
REQ-033 SHALL allow the first accept on the first edge after rst_n deasserts.

Structure
REQ-034 SHALL take from shared package binary16_pkg: the field widths, BIAS=15, EXP_MAX=30, EXP_INF=31, QNAN/INF/MAXFIN constants and the FSM state typedef.
REQ-035 SHALL place the iterative mantissa datapath (remainder, quotient, counter) in one sub-module, mant_divider_seq, with start and done handshake; the FSM and special-case logic stay in the top module.

Verification
REQ-036 SHALL cover: a=0x4600, b=0x4000 -> result=0x4200, data_valid_out high exactly 13 cycles after accept, busy low after DONE.
REQ-037 SHALL cover: a=0x3C00, b=0x4200 -> 0x3555 (truncated 1/3); and a=0xBC00, b=0x3800 -> 0xC000.
REQ-038 SHALL cover: a=0x3C00, b=0x0000 -> 0x7C00 with div_by_zero=1; and a=0x0000, b=0xC000 -> 0x8000 with div_by_zero=0.
REQ-039 SHALL cover: a=0x7BFF, b=0x0400 -> 0x7C00 (SAT_TO_INF=1) or 0x7BFF (SAT_TO_INF=0); and a=0x0400, b=0x7BFF -> 0x0000.
REQ-040 SHALL cover: a second data_valid_in pulsed mid-DIVIDE is ignored (only the first result appears).
REQ-041 SHALL cover: rst_n pulsed low mid-DIVIDE yields no data_valid_out, and a fresh accept afterwards gives the correct result.

Source files
------------

// File: rtl/binary16_pkg.sv
// ----------------------------------------------------------------------------
// binary16_pkg
//   Shared definitions for the binary16 divider: field widths, exponent
//   limits, special encodings and the controller state type.
// ----------------------------------------------------------------------------
package binary16_pkg;

    localparam int EXP_W   = 5;
    localparam int MANT_W  = 10;
    localparam int SIG_W   = MANT_W + 1;   // significand with hidden bit

    localparam int BIAS    = 15;
    localparam int EXP_MAX = 30;
    localparam int EXP_INF = 31;

    localparam logic [15:0] QNAN   = 16'h7E00;
    localparam logic [15:0] INF    = 16'h7C00;
    localparam logic [15:0] MAXFIN = 16'h7BFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        NORM   = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/binary16_divider_if.sv
// ----------------------------------------------------------------------------
// binary16_divider_if
//   Operand / result bundle of the binary16 divider.
//   a, b, data_valid_in         : operands and strobe (master -> slave)
//   result, data_valid_out,
//   div_by_zero, busy           : quotient, strobe, flag, activity (slave -> master)
// ----------------------------------------------------------------------------
interface binary16_divider_if;

    logic [15:0] a;
    logic [15:0] b;
    logic        data_valid_in;
    logic [15:0] result;
    logic        data_valid_out;
    logic        div_by_zero;
    logic        busy;

    modport master (
        output a, b, data_valid_in,
        input  result, data_valid_out, div_by_zero, busy
    );

    modport slave (
        input  a, b, data_valid_in,
        output result, data_valid_out, div_by_zero, busy
    );

endinterface

// File: rtl/mant_divider_seq.sv
// ----------------------------------------------------------------------------
// mant_divider_seq
//   Restoring significand divider, one quotient bit per cycle, MSB first.
//   i_start loads the operands; o_done is high during the cycle whose edge
//   retires the last bit, so o_q is complete on the following cycle.
//   Ports: clk_in, rst_n, i_start, i_dividend, i_divisor -> o_done, o_q
// ----------------------------------------------------------------------------
module mant_divider_seq
    import binary16_pkg::*;
#(
    parameter int QBITS = 12
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [SIG_W-1:0]  i_dividend,
    input  logic [SIG_W-1:0]  i_divisor,
    output logic              o_done,
    output logic [QBITS-1:0]  o_q
);

    localparam int CNT_W = $clog2(QBITS + 1);

    // Partial remainder needs one guard bit: after a step it is < divisor,
    // and the shift doubles it.
    logic [SIG_W:0]     r_rem;
    logic [SIG_W-1:0]   r_div;
    logic [QBITS-1:0]   r_q;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_run;

    logic               w_ge;
    logic [SIG_W:0]     w_rem_nxt;

    assign w_ge      = (r_rem >= {1'b0, r_div});
    assign w_rem_nxt = w_ge ? (r_rem - {1'b0, r_div}) : r_rem;

    assign o_done = r_run && (r_cnt == CNT_W'(QBITS - 1));
    assign o_q    = r_q;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_rem <= '0;
            r_div <= '0;
            r_q   <= '0;
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_start) begin
            r_rem <= {1'b0, i_dividend};
            r_div <= i_divisor;
            r_q   <= '0;
            r_cnt <= '0;
            r_run <= 1'b1;
        end else if (r_run) begin
            r_q   <= {r_q[QBITS-2:0], w_ge};
            r_rem <= w_rem_nxt << 1;
            if (o_done) begin
                r_run <= 1'b0;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/binary16_divider.sv
// ----------------------------------------------------------------------------
// binary16_divider
//   Sequential binary16 divide a/b with truncating rounding and a fixed
//   latency: accept, QBITS divide cycles, one normalise cycle, one DONE
//   cycle carrying the result strobe.
//   Ports: clk_in, rst_n (async, active low), bus (slave modport:
//          a, b, data_valid_in -> result, data_valid_out, div_by_zero, busy)
//   Params: SAT_TO_INF (overflow -> Inf when 1, max finite when 0),
//           QBITS (quotient bits developed, >= 12)
// ----------------------------------------------------------------------------
module binary16_divider
    import binary16_pkg::*;
#(
    parameter bit SAT_TO_INF = 1'b1,
    parameter int QBITS      = 12
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    binary16_divider_if.slave    bus
);

    localparam logic signed [6:0] BIAS_S  = 7'(BIAS);
    localparam logic signed [6:0] EXP_HI  = 7'(EXP_MAX);
    localparam logic signed [6:0] EXP_LO  = 7'sd1;

    state_t             r_state, w_state_nxt;

    logic               r_sign;
    logic               r_a_zero;
    logic               r_b_zero;
    logic signed [6:0]  r_exp;
    logic [15:0]        r_result;
    logic               r_dbz;

    logic               w_accept;
    logic               w_div_done;
    logic [QBITS-1:0]   w_q;
    logic               w_q_hi;
    logic [MANT_W-1:0]  w_frac;
    logic signed [6:0]  w_exp_adj;
    logic [15:0]        w_res;
    logic               w_dbz;

    assign w_accept = (r_state == IDLE) && bus.data_valid_in;

    mant_divider_seq #(.QBITS(QBITS)) u_mant (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .i_start    (w_accept),
        .i_dividend ({1'b1, bus.a[MANT_W-1:0]}),
        .i_divisor  ({1'b1, bus.b[MANT_W-1:0]}),
        .o_done     (w_div_done),
        .o_q        (w_q)
    );

    // ---------------- controller ----------------
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.data_valid_in) w_state_nxt = DIVIDE;
            DIVIDE:  if (w_div_done)        w_state_nxt = NORM;
            NORM:                           w_state_nxt = DONE;
            DONE:                           w_state_nxt = IDLE;
            default:                        w_state_nxt = IDLE;
        endcase
    end

    // ---------------- operand capture ----------------
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_sign   <= 1'b0;
            r_a_zero <= 1'b0;
            r_b_zero <= 1'b0;
            r_exp    <= '0;
        end else if (w_accept) begin
            r_sign   <= bus.a[15] ^ bus.b[15];
            r_a_zero <= (bus.a[14:0] == 15'h0);
            r_b_zero <= (bus.b[14:0] == 15'h0);
            r_exp    <= $signed({2'b00, bus.a[14:10]})
                      - $signed({2'b00, bus.b[14:10]}) + BIAS_S;
        end
    end

    // ---------------- normalise and special cases ----------------
    // Significand ratio lies in (0.5, 2): the top quotient bit is the
    // integer bit; when clear, the next bit is the leading one instead.
    assign w_q_hi    = w_q[QBITS-1];
    assign w_frac    = w_q_hi ? w_q[QBITS-2 -: MANT_W] : w_q[QBITS-3 -: MANT_W];
    assign w_exp_adj = w_q_hi ? r_exp : (r_exp - 7'sd1);

    always_comb begin
        w_res = {r_sign, w_exp_adj[EXP_W-1:0], w_frac};
        w_dbz = 1'b0;
        if (r_b_zero) begin
            w_res = {r_sign, INF[14:0]};
            w_dbz = 1'b1;
        end else if (r_a_zero) begin
            w_res = {r_sign, 15'h0};
        end else if (w_exp_adj > EXP_HI) begin
            w_res = SAT_TO_INF ? {r_sign, INF[14:0]} : {r_sign, MAXFIN[14:0]};
        end else if (w_exp_adj < EXP_LO) begin
            w_res = {r_sign, 15'h0};
        end
    end

    // Output registers load only on the NORM->DONE edge and clear on every
    // other edge, so they read zero whenever the strobe is low.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_dbz    <= 1'b0;
        end else if (r_state == NORM) begin
            r_result <= w_res;
            r_dbz    <= w_dbz;
        end else begin
            r_result <= '0;
            r_dbz    <= 1'b0;
        end
    end

    assign bus.result         = r_result;
    assign bus.div_by_zero    = r_dbz;
    assign bus.data_valid_out = (r_state == DONE);
    assign bus.busy           = (r_state != IDLE);

endmodule

// File: tb/tb_binary16_divider.sv
// ----------------------------------------------------------------------------
// tb_binary16_divider
//   Directed vectors with hand-computed quotients; expected responses are
//   queued at accept and checked by an independent monitor on data_valid_out.
// ----------------------------------------------------------------------------
module tb_binary16_divider;

    localparam int LATENCY = 13;

    typedef struct {
        logic [15:0] res;
        logic        dbz;
        int          acc;
        string       name;
    } exp_t;

    logic clk_in;
    logic rst_n;
    int   cyc;
    int   n_chk;
    int   n_pass;
    bit   chk_after;
    exp_t sb[$];

    binary16_divider_if bus ();

    binary16_divider #(.SAT_TO_INF(1'b1), .QBITS(12)) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    // Drive one operand strobe; optionally queue its expected response.
    task automatic op(input logic [15:0] ta, input logic [15:0] tb_v,
                      input logic [15:0] er, input logic ed,
                      input string nm, input bit push);
        exp_t e;
        @(negedge clk_in);
        bus.a = ta;
        bus.b = tb_v;
        bus.data_valid_in = 1'b1;
        @(posedge clk_in);
        #1;
        bus.data_valid_in = 1'b0;
        if (push) begin
            e.res  = er;
            e.dbz  = ed;
            e.acc  = cyc;
            e.name = nm;
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk_in);
        while (bus.busy && n < 40) begin
            @(negedge clk_in);
            n++;
        end
        if (bus.busy) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    // Monitor: compares every strobe against the scoreboard head.
    always @(negedge clk_in) begin
        exp_t e;
        if (rst_n) begin
            if (chk_after) begin
                chk("busy_after_done", {31'd0, bus.busy}, 32'd0);
                chk("valid_one_cycle", {31'd0, bus.data_valid_out}, 32'd0);
                chk_after = 1'b0;
            end
            if (bus.data_valid_out) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_result"}, {16'd0, bus.result}, {16'd0, e.res});
                    chk({e.name, "_dbz"}, {31'd0, bus.div_by_zero}, {31'd0, e.dbz});
                    chk({e.name, "_latency"}, cyc - e.acc, LATENCY);
                end
                chk_after = 1'b1;
            end else begin
                chk("idle_outputs_zero", {15'd0, bus.result, bus.div_by_zero}, 32'd0);
            end
        end else begin
            chk_after = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_chk = 0;
        n_pass = 0;
        chk_after = 1'b0;
        rst_n = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.data_valid_in = 1'b0;

        repeat (3) @(negedge clk_in);
        chk("reset_busy",   {31'd0, bus.busy}, 32'd0);
        chk("reset_valid",  {31'd0, bus.data_valid_out}, 32'd0);
        chk("reset_result", {15'd0, bus.result, bus.div_by_zero}, 32'd0);
        @(posedge clk_in);
        #1 rst_n = 1'b1;

        // Main function and special cases
        op(16'h4600, 16'h4000, 16'h4200, 1'b0, "six_by_two", 1'b1);
        @(negedge clk_in);
        chk("busy_in_flight", {31'd0, bus.busy}, 32'd1);
        wait_idle();
        op(16'h3C00, 16'h4200, 16'h3555, 1'b0, "one_third", 1'b1);        wait_idle();
        op(16'hBC00, 16'h3800, 16'hC000, 1'b0, "neg_by_half", 1'b1);      wait_idle();
        op(16'h3C00, 16'h0000, 16'h7C00, 1'b1, "div_zero", 1'b1);         wait_idle();
        op(16'h0000, 16'hC000, 16'h8000, 1'b0, "zero_dividend", 1'b1);    wait_idle();
        op(16'h7BFF, 16'h0400, 16'h7C00, 1'b0, "overflow", 1'b1);         wait_idle();
        op(16'h0400, 16'h7BFF, 16'h0000, 1'b0, "underflow", 1'b1);        wait_idle();

        // Second strobe mid-DIVIDE must be ignored
        op(16'h4600, 16'h4000, 16'h4200, 1'b0, "ignore_first", 1'b1);
        repeat (4) @(negedge clk_in);
        op(16'h3C00, 16'h4200, 16'h0000, 1'b0, "ignored", 1'b0);
        wait_idle();
        repeat (20) @(negedge clk_in);

        // Reset mid-DIVIDE discards the operation
        op(16'h3C00, 16'h4200, 16'h0000, 1'b0, "discarded", 1'b0);
        repeat (5) @(negedge clk_in);
        rst_n = 1'b0;
        #1;
        chk("midreset_busy",   {31'd0, bus.busy}, 32'd0);
        chk("midreset_valid",  {31'd0, bus.data_valid_out}, 32'd0);
        chk("midreset_result", {15'd0, bus.result, bus.div_by_zero}, 32'd0);
        repeat (2) @(posedge clk_in);
        #1 rst_n = 1'b1;
        op(16'hBC00, 16'h3800, 16'hC000, 1'b0, "after_reset", 1'b1);
        wait_idle();
        repeat (20) @(negedge clk_in);

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
